pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and pipeline-control block for the 5-stage pipeline. It reads the decode/execute register outputs (the de_* control and register fields) plus the register specifiers of the instruction currently in decode. From these it drives stall and flush controls back into the PC, fetch/decode and decode/execute registers. It covers load-use stalls, branch/jump redirect flushes and multi-cycle mul/div occupancy of execute, and keeps saturating stall/flush event counters.

## Interface
Parameters:
- MULDIV_CYCLES, default 4: total execute-stage occupancy of a mul/div instruction, in cycles; legal range 2..255.
- CNT_W, default 16: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- id_rs1_i  in  5  rs1 of instruction in decode.
- id_rs2_i  in  5  rs2 of instruction in decode.
- id_use_rs1_i  in  1  decode instruction reads rs1.
- id_use_rs2_i  in  1  decode instruction reads rs2.
- de_rd_i  in  5  rd of instruction in execute.
- de_reg_write_i  in  1  execute instruction writes rd.
- de_mem_read_i  in  1  execute instruction is a load.
- de_isbranchtaken_i  in  1  execute branch resolved taken.
- de_jump_i  in  1  execute instruction is a jump.
- de_muldiv_i  in  1  execute instruction is mul/div.
- pc_stall_o  out  1  hold PC.
- fd_stall_o  out  1  hold fetch/decode register.
- fd_flush_o  out  1  load NOP into fetch/decode register.
- de_stall_o  out  1  hold decode/execute register.
- de_flush_o  out  1  load bubble (all control bits 0) into decode/execute register.
- em_bubble_o  out  1  load bubble into execute/memory register.
- muldiv_done_o  out  1  last execute cycle of a mul/div.
- stall_cycles_o  out  CNT_W  saturating count of cycles with pc_stall_o=1.
- flush_events_o  out  CNT_W  saturating count of redirect flushes.

## Operation
- FSM states: RUN, MD_BUSY. Registered down-counter md_cnt is 8 bits.
- Events are evaluated combinationally each cycle:
  - redirect = de_isbranchtaken_i | de_jump_i.
  - md_start = (state==RUN) & de_muldiv_i & ~redirect.
  - load_use = de_mem_read_i & de_reg_write_i & (de_rd_i!=0) & ((id_use_rs1_i & id_rs1_i==de_rd_i) | (id_use_rs2_i & id_rs2_i==de_rd_i)).
- Priority: redirect > mul/div busy > load-use.
- Redirect (state RUN only):
  - fd_flush_o=1, de_flush_o=1; no stalls.
  - flush_events_o increments.
  - md_start and load_use are suppressed.
- Mul/div busy, active when md_start=1 or (state==MD_BUSY and md_cnt!=0):
  - pc_stall_o=fd_stall_o=de_stall_o=1, em_bubble_o=1.
  - load_use is suppressed.
- Mul/div transitions:
  - md_start moves the FSM to MD_BUSY and loads md_cnt=MULDIV_CYCLES-2.
  - In MD_BUSY with md_cnt!=0: md_cnt decrements.
  - In MD_BUSY with md_cnt==0: no stall outputs, muldiv_done_o=1, FSM returns to RUN next edge.
  - The mul/div therefore occupies execute for exactly MULDIV_CYCLES cycles. It cannot retrigger, because decode/execute advances at that edge.
- Load-use (state RUN, no redirect, no busy):
  - pc_stall_o=1, fd_stall_o=1, de_flush_o=1 for one cycle.
  - The bubble clears the condition next cycle.
- Redirect and de_muldiv_i together is illegal; redirect wins and no mul/div is started.
- In MD_BUSY, redirect inputs are ignored, because the execute instruction is the mul/div.
- Counters:
  - stall_cycles_o increments on each cycle with pc_stall_o=1.
  - Both counters saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from inputs and registered state, with zero-cycle latency: they act at the same edge the hazard is seen.
- Reset (rst_ni=0, asynchronous):
  - state=RUN, md_cnt=0, both counters=0.
  - All control outputs, including muldiv_done_o, are forced 0 while reset is asserted.
- Reset asserted mid-MD_BUSY aborts the operation immediately; no muldiv_done_o pulse follows.
- Reset deassertion is synchronised externally; the first active edge behaves as RUN.
- A load-use costs exactly one stall cycle. A redirect costs two flushed slots, asserted in one cycle.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - state enum (RUN, MD_BUSY).
  - REG_ZERO = 5'd0.
  - MD_CNT_W = 8.
- The team already uses pipe_ctrl_pkg for other pipeline-control definitions.
- One sub-module, sat_counter (parameter CNT_W, inputs inc_i/clk_i/rst_ni, output count_o), instantiated twice.

## Test plan
- Load-use: de_mem_read_i=1, de_reg_write_i=1, de_rd_i=5, id_rs1_i=5, id_use_rs1_i=1 → one cycle pc_stall_o=fd_stall_o=de_flush_o=1; stall_cycles_o=1.
- Load to x0: same with de_rd_i=0 → no stall, all outputs 0.
- Taken branch coinciding with load-use: de_isbranchtaken_i=1 plus the load-use condition → fd_flush_o=de_flush_o=1, pc_stall_o=0, flush_events_o=1.
- Mul/div, MULDIV_CYCLES=4: de_muldiv_i=1 held → stalls and em_bubble_o high for 3 cycles, muldiv_done_o high in cycle 4, then RUN; stall_cycles_o=3.
- Reset mid-mul/div: assert rst_ni=0 in busy cycle 2 → all outputs 0 immediately, counters 0; after release, de_muldiv_i=0 → no done pulse.
- Saturation, CNT_W=4: 20 load-use stalls → stall_cycles_o=15, held at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and common constants.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         MD_CNT_W = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: counts inc_i cycles and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control: load-use stalls, redirect flushes and mul/div
// occupancy of execute, with saturating stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [4:0]       de_rd_i,
    input  logic             de_reg_write_i,
    input  logic             de_mem_read_i,
    input  logic             de_isbranchtaken_i,
    input  logic             de_jump_i,
    input  logic             de_muldiv_i,
    output logic             pc_stall_o,
    output logic             fd_stall_o,
    output logic             fd_flush_o,
    output logic             de_stall_o,
    output logic             de_flush_o,
    output logic             em_bubble_o,
    output logic             muldiv_done_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    state_e                state_q, state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

    logic redirect, md_start, load_use, md_busy, md_last;
    logic redirect_act, load_use_act;

    assign redirect = de_isbranchtaken_i | de_jump_i;
    assign md_start = (state_q == RUN) & de_muldiv_i & ~redirect;
    assign load_use = de_mem_read_i & de_reg_write_i & (de_rd_i != REG_ZERO) &
                      ((id_use_rs1_i & (id_rs1_i == de_rd_i)) |
                       (id_use_rs2_i & (id_rs2_i == de_rd_i)));

    assign md_busy      = md_start | ((state_q == MD_BUSY) & (md_cnt_q != '0));
    assign md_last      = (state_q == MD_BUSY) & (md_cnt_q == '0);
    assign redirect_act = (state_q == RUN) & redirect;
    assign load_use_act = (state_q == RUN) & ~redirect & ~md_busy & load_use;

    // Outputs are held low while reset is asserted, independent of the clock.
    always_comb begin
        pc_stall_o    = 1'b0;
        fd_stall_o    = 1'b0;
        fd_flush_o    = 1'b0;
        de_stall_o    = 1'b0;
        de_flush_o    = 1'b0;
        em_bubble_o   = 1'b0;
        muldiv_done_o = 1'b0;
        if (rst_ni) begin
            pc_stall_o    = md_busy | load_use_act;
            fd_stall_o    = md_busy | load_use_act;
            fd_flush_o    = redirect_act;
            de_stall_o    = md_busy;
            de_flush_o    = redirect_act | load_use_act;
            em_bubble_o   = md_busy;
            muldiv_done_o = md_last;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            RUN: begin
                if (md_start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = MD_CNT_W'(MULDIV_CYCLES - 2);
                end
            end
            MD_BUSY: begin
                if (md_cnt_q != '0) begin
                    md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (pc_stall_o),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (fd_flush_o),
        .count_o (flush_events_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised + directed bench for pipe_hazard_ctrl, two parameterisations
// driven by the same stimulus and checked against a cycle-level model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       ur1, ur2, rw, mem, br, jmp, md;

    logic        pcs0, fds0, fdf0, des0, def0, emb0, dn0;
    logic        pcs1, fds1, fdf1, des1, def1, emb1, dn1;
    logic [15:0] stc0, flc0;
    logic [3:0]  stc1, flc1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state per instance: md_k = index of current mul/div cycle (0 = none)
    int md_k [2];
    int scnt [2];
    int fcnt [2];
    int nmd  [2];
    int maxc [2];

    logic [6:0] obs_ctl [2];
    int         obs_st  [2];
    int         obs_fl  [2];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULDIV_CYCLES(4), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(ur1), .id_use_rs2_i(ur2),
        .de_rd_i(rd), .de_reg_write_i(rw), .de_mem_read_i(mem),
        .de_isbranchtaken_i(br), .de_jump_i(jmp), .de_muldiv_i(md),
        .pc_stall_o(pcs0), .fd_stall_o(fds0), .fd_flush_o(fdf0),
        .de_stall_o(des0), .de_flush_o(def0), .em_bubble_o(emb0),
        .muldiv_done_o(dn0), .stall_cycles_o(stc0), .flush_events_o(flc0)
    );

    pipe_hazard_ctrl #(.MULDIV_CYCLES(3), .CNT_W(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(ur1), .id_use_rs2_i(ur2),
        .de_rd_i(rd), .de_reg_write_i(rw), .de_mem_read_i(mem),
        .de_isbranchtaken_i(br), .de_jump_i(jmp), .de_muldiv_i(md),
        .pc_stall_o(pcs1), .fd_stall_o(fds1), .fd_flush_o(fdf1),
        .de_stall_o(des1), .de_flush_o(def1), .em_bubble_o(emb1),
        .muldiv_done_o(dn1), .stall_cycles_o(stc1), .flush_events_o(flc1)
    );

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control vector {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_bubble, done}
    task automatic model_eval(input int i, output logic [6:0] ctl, output int nk);
        logic lu;
        lu  = mem && rw && (rd != 5'd0) &&
              ((ur1 && (rs1 == rd)) || (ur2 && (rs2 == rd)));
        ctl = 7'b0000000;
        nk  = md_k[i];
        if (!rst_n) begin
            nk = 0;
        end else if (md_k[i] == 0) begin
            if (br || jmp)   ctl = 7'b0010100;
            else if (md) begin
                ctl = 7'b1101010;
                nk  = 2;
            end else if (lu) ctl = 7'b1100100;
        end else if (md_k[i] < nmd[i]) begin
            ctl = 7'b1101010;
            nk  = md_k[i] + 1;
        end else begin
            ctl = 7'b0000001;
            nk  = 0;
        end
    endtask

    // Inputs already applied just after a falling edge; sample, compare,
    // advance the model across the next rising edge, return at the next falling edge.
    task automatic tick();
        logic [6:0] ctl;
        int         nk;
        #1;
        obs_ctl[0] = {pcs0, fds0, fdf0, des0, def0, emb0, dn0};
        obs_ctl[1] = {pcs1, fds1, fdf1, des1, def1, emb1, dn1};
        obs_st[0]  = int'(stc0);
        obs_fl[0]  = int'(flc0);
        obs_st[1]  = int'(stc1);
        obs_fl[1]  = int'(flc1);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                md_k[i] = 0;
                scnt[i] = 0;
                fcnt[i] = 0;
            end
            model_eval(i, ctl, nk);
            check($sformatf("ctl%0d", i), int'(obs_ctl[i]), int'(ctl));
            check($sformatf("stall_cnt%0d", i), obs_st[i], scnt[i]);
            check($sformatf("flush_cnt%0d", i), obs_fl[i], fcnt[i]);
            if (ctl[6] && scnt[i] < maxc[i]) scnt[i]++;
            if (ctl[4] && fcnt[i] < maxc[i]) fcnt[i]++;
            md_k[i] = nk;
        end
        $display("[TB] t=%0t rst_n=%0b br=%0b jmp=%0b md=%0b lu_in=%0b rd=%0d ctl0=%b ctl1=%b st0=%0d fl0=%0d st1=%0d",
                 $time, rst_n, br, jmp, md, mem, rd, obs_ctl[0], obs_ctl[1], obs_st[0], obs_fl[0], obs_st[1]);
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; ur1 = 1'b0; ur2 = 1'b0;
        rd = 5'd0; rw = 1'b0; mem = 1'b0; br = 1'b0; jmp = 1'b0; md = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        idle();
        mem = 1'b1; rw = 1'b1; rd = r; rs1 = r; ur1 = 1'b1;
    endtask

    initial begin
        nmd[0] = 4; maxc[0] = 65535;
        nmd[1] = 3; maxc[1] = 15;
        for (int i = 0; i < 2; i++) begin
            md_k[i] = 0; scnt[i] = 0; fcnt[i] = 0;
        end
        idle();
        rst_n = 1'b0;
        @(negedge clk);

        // Reset state
        tick();
        check("reset_ctl", int'(obs_ctl[0]), 0);
        check("reset_stall", obs_st[0], 0);
        check("reset_flush", obs_fl[0], 0);
        rst_n = 1'b1;
        tick();

        // Load-use: one stall cycle
        set_lu(5'd5);
        tick();
        check("lu_ctl", int'(obs_ctl[0]), 32'b1100100);
        idle();
        tick();
        check("lu_after_ctl", int'(obs_ctl[0]), 0);
        check("lu_stall_cnt", obs_st[0], 1);

        // Load to x0: no hazard
        set_lu(5'd0);
        tick();
        check("x0_ctl", int'(obs_ctl[0]), 0);

        // Taken branch beats load-use
        set_lu(5'd5);
        br = 1'b1;
        tick();
        check("br_lu_ctl", int'(obs_ctl[0]), 32'b0010100);
        idle();
        tick();
        check("br_flush_cnt", obs_fl[0], 1);
        check("br_stall_cnt", obs_st[0], 1);

        // Mul/div held: three busy cycles then done
        md = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("md_cyc%0d", k), int'(obs_ctl[0]), (k < 4) ? 32'b1101010 : 32'b0000001);
        end
        idle();
        tick();
        check("md_after_ctl", int'(obs_ctl[0]), 0);
        check("md_stall_cnt", obs_st[0], 4);
        for (int k = 0; k < 4; k++) tick();

        // Reset in mul/div busy cycle 2 aborts with no done pulse
        md = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        check("md_rst_ctl", int'(obs_ctl[0]), 0);
        check("md_rst_stall", obs_st[0], 0);
        check("md_rst_flush", obs_fl[0], 0);
        rst_n = 1'b1;
        md = 1'b0;
        tick();
        check("md_rst_nodone0", int'(obs_ctl[0]), 0);
        tick();
        check("md_rst_nodone1", int'(obs_ctl[0]), 0);

        // Saturation of the 4-bit counter
        set_lu(5'd7);
        for (int k = 0; k < 20; k++) tick();
        idle();
        tick();
        check("sat_cnt4", obs_st[1], 15);
        check("sat_cnt16", obs_st[0], 20);
        tick();
        check("sat_hold", obs_st[1], 15);

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            br    = ($urandom_range(0, 7) == 0);
            jmp   = ($urandom_range(0, 15) == 0);
            md    = ($urandom_range(0, 5) == 0);
            mem   = ($urandom_range(0, 1) == 0);
            rw    = ($urandom_range(0, 3) != 0);
            rd    = 5'($urandom_range(0, 7));
            rs1   = 5'($urandom_range(0, 7));
            rs2   = 5'($urandom_range(0, 7));
            ur1   = ($urandom_range(0, 1) == 0);
            ur2   = ($urandom_range(0, 1) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
